ms_timeout_timer: RTL and testbench

Downstream consumer of the divider's millisecond clock. Synchronises the free-running ms_clk toggle (sb_clk domain) into the fsm_clk domain and turns each edge into a 1 ms tick. Runs one programmable millisecond timeout for the logical-layer FSMs, e.g. sideband response, training and disconnect timeouts. One timer per instance; the FSM instantiates one per concurrent timeout.

---
 rtl/ms_timeout_timer_pkg.sv | 19 +
 rtl/ms_timeout_timer_if.sv | 36 +++
 rtl/ms_timeout_timer_ms_tick_sync.sv | 39 +++
 rtl/ms_timeout_timer.sv | 96 +++++++++
 tb/tb_ms_timeout_timer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ms_timeout_timer_pkg.sv
// usb4_timer_pkg: shared state encoding, default counter width and named
// timeout lengths for the logical-layer millisecond timers.
// Expiry lands on the Nth tick after start, so the true elapsed time is in
// (N-1, N] ms; the constants below already include the extra tick.
package usb4_timer_pkg;

  localparam int unsigned TMR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } tmr_state_e;

  localparam logic [TMR_CNT_W-1:0] T_SB_RSP_MS     = 8'd3;
  localparam logic [TMR_CNT_W-1:0] T_TRAIN_MS      = 8'd101;
  localparam logic [TMR_CNT_W-1:0] T_DISCONNECT_MS = 8'd51;

endpackage

// File: rtl/ms_timeout_timer_if.sv
// Control/status bundle between a logical-layer FSM (master) and one
// ms_timeout_timer (slave). elapsed_ms exists only with TIMER_ELAPSED_EN.
interface ms_timeout_timer_if
  import usb4_timer_pkg::*;
#(
  parameter int unsigned CNT_W = TMR_CNT_W
) ();

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] timeout_ms;
  logic             ms_tick;
  logic             busy;
  logic             timeout;
  logic             expired;
`ifdef TIMER_ELAPSED_EN
  logic [CNT_W-1:0] elapsed_ms;
`endif

  modport master (
    output start, stop, timeout_ms,
    input  ms_tick, busy, timeout, expired
`ifdef TIMER_ELAPSED_EN
    , input elapsed_ms
`endif
  );

  modport slave (
    input  start, stop, timeout_ms,
    output ms_tick, busy, timeout, expired
`ifdef TIMER_ELAPSED_EN
    , output elapsed_ms
`endif
  );

endinterface

// File: rtl/ms_timeout_timer_ms_tick_sync.sv
// ms_tick_sync: brings the free-running ms_clk toggle into the fsm_clk
// domain and emits a one-cycle pulse on every edge of either polarity.
// Edge-to-pulse latency is SYNC_STAGES+1 fsm_clk cycles.
module ms_tick_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic fsm_clk,
  input  logic rst,
  input  logic ms_clk,
  output logic ms_tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   tick_q, tick_d;

  // Shift ms_clk through the chain, remember the last synced level, compare.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ms_clk};
    hist_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] ^ hist_q;
  end

  // Synchroniser, history and pulse registers.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      tick_q <= tick_d;
    end
  end

  assign ms_tick = tick_q;

endmodule

// File: rtl/ms_timeout_timer.sv
// ms_timeout_timer: one programmable millisecond timeout driven by the
// divider's ms_clk toggle. Optional macro TIMER_ELAPSED_EN exposes the
// running tick count as elapsed_ms.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | no timeout armed
//   RUNNING | counting ms ticks towards the loaded length
//   EXPIRED | length reached; held until start or stop
module ms_timeout_timer
  import usb4_timer_pkg::*;
#(
  parameter int unsigned CNT_W       = TMR_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              fsm_clk,
  input  logic              rst,
  input  logic              ms_clk,
  ms_timeout_timer_if.slave tmr
);

  logic             ms_tick;
  tmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] count_inc;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic             timeout_q, timeout_d;

  ms_tick_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_tick_sync (
    .fsm_clk (fsm_clk),
    .rst     (rst),
    .ms_clk  (ms_clk),
    .ms_tick (ms_tick)
  );

  // Next state: stop beats start beats tick; a zero length expires at once.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    load_d    = load_q;
    timeout_d = 1'b0;
    count_inc = count_q + CNT_W'(1);
    if (tmr.stop) begin
      state_d = IDLE;
    end else if (tmr.start) begin
      load_d  = tmr.timeout_ms;
      count_d = '0;
      if (tmr.timeout_ms == '0) begin
        state_d   = EXPIRED;
        timeout_d = 1'b1;
      end else begin
        state_d = RUNNING;
      end
    end else if ((state_q == RUNNING) && ms_tick) begin
      count_d = count_inc;
      if (count_inc == load_q) begin
        state_d   = EXPIRED;
        timeout_d = 1'b1;
      end
    end
    busy_d    = (state_d == RUNNING);
    expired_d = (state_d == EXPIRED);
  end

  // State, counter and registered status outputs.
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      load_q    <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      timeout_q <= timeout_d;
    end
  end

  assign tmr.ms_tick = ms_tick;
  assign tmr.busy    = busy_q;
  assign tmr.expired = expired_q;
  assign tmr.timeout = timeout_q;
`ifdef TIMER_ELAPSED_EN
  assign tmr.elapsed_ms = count_q;
`endif

endmodule

// File: tb/tb_ms_timeout_timer.sv
// Directed bench for ms_timeout_timer (CNT_W=8, SYNC_STAGES=2).
// Elapsed checks compile in when TIMER_ELAPSED_EN is defined.
module tb_ms_timeout_timer;

  logic fsm_clk = 1'b0;
  logic rst     = 1'b0;
  logic ms_clk;

  ms_timeout_timer_if #(.CNT_W(8)) bus ();

  ms_timeout_timer #(
    .CNT_W       (8),
    .SYNC_STAGES (2)
  ) dut (
    .fsm_clk (fsm_clk),
    .rst     (rst),
    .ms_clk  (ms_clk),
    .tmr     (bus.slave)
  );

  always #5 fsm_clk = ~fsm_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ms_mode = 1;        // 0: ms_clk held low, 1: fast toggle, 2: 50-cycle toggle
  int div_cnt = 0;
  int edge_cyc = -1000;
  int tick_cnt = 0;
  int tmo_cnt  = 0;
  int last_tick_cyc = 0;
  int last_tmo_cyc  = 0;
  int pulse_cyc     = 0;
  logic prev_tick = 1'b0;
  logic prev_tmo  = 1'b0;

  typedef struct {
    logic [7:0] tmo;
    int         ticks;
    logic       exp_busy;
    logic       exp_expired;
    int         exp_tmo;
  } vec_t;

  vec_t vecs[7];

  always @(posedge fsm_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ms_clk generator: all changes land 2 ns after a rising fsm_clk edge.
  initial begin
    ms_clk = 1'b0;
    forever begin
      @(posedge fsm_clk); #2;
      if (ms_mode == 0) begin
        ms_clk  = 1'b0;
        div_cnt = 0;
      end else if (ms_mode == 1) begin
        div_cnt++;
        if (div_cnt >= 3) begin
          div_cnt = 0;
          ms_clk  = ~ms_clk;
        end
      end else begin
        div_cnt++;
        if (div_cnt >= 50) begin
          div_cnt  = 0;
          ms_clk   = ~ms_clk;
          edge_cyc = cyc;
        end
      end
    end
  end

  // Output monitor: tick latency/width, timeout width, event counters.
  initial begin
    forever begin
      @(posedge fsm_clk); #1;
      if (ms_mode == 2 && (bus.ms_tick || (cyc - edge_cyc == 3)))
        check("tick_latency", bus.ms_tick, (cyc - edge_cyc == 3) ? 1 : 0);
      if (bus.ms_tick) begin
        check("tick_width", prev_tick, 0);
        tick_cnt++;
        last_tick_cyc = cyc;
      end
      if (bus.timeout) begin
        check("timeout_width", prev_tmo, 0);
        tmo_cnt++;
        last_tmo_cyc = cyc;
      end
      prev_tick = bus.ms_tick;
      prev_tmo  = bus.timeout;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000 ns");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int k);
    int target;
    int budget;
    target = tick_cnt + k;
    budget = k * 60 + 20;
    while (tick_cnt < target && budget > 0) begin
      @(posedge fsm_clk); #3;
      budget--;
    end
    if (tick_cnt < target) check("tick_wait", tick_cnt, target);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge fsm_clk);
    #3;
  endtask

  task automatic pulse(input logic s, input logic p, input logic [7:0] t);
    bus.start      = s;
    bus.stop       = p;
    bus.timeout_ms = t;
    @(posedge fsm_clk); #3;
    pulse_cyc = cyc;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  // Step just past a tick, then return the timer to IDLE.
  task automatic align_idle();
    wait_ticks(1);
    pulse(1'b0, 1'b1, 8'd0);
  endtask

  initial begin
    int base;
    vecs[0] = '{8'd3, 2, 1'b1, 1'b0, 0};
    vecs[1] = '{8'd3, 3, 1'b0, 1'b1, 1};
    vecs[2] = '{8'd1, 1, 1'b0, 1'b1, 1};
    vecs[3] = '{8'd0, 0, 1'b0, 1'b1, 1};
    vecs[4] = '{8'd4, 5, 1'b0, 1'b1, 1};
    vecs[5] = '{8'd6, 4, 1'b1, 1'b0, 0};
    vecs[6] = '{8'd2, 1, 1'b1, 1'b0, 0};

    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.timeout_ms = 8'd0;

    // Reset held while ms_clk toggles fast.
    cycles(4);
    for (int i = 0; i < 4; i++) begin
      cycles(5);
      check("reset_outputs", {bus.ms_tick, bus.busy, bus.expired, bus.timeout}, 0);
    end
    ms_mode = 0;
    cycles(5);
    rst = 1'b1;
    cycles(12);
    check("no_tick_after_reset", tick_cnt, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_expired", bus.expired, 0);

    // Free-running ticks on both ms_clk polarities.
    ms_mode = 2;
    wait_ticks(3);
    check("tick_count", tick_cnt, 3);

    // Table-driven: start aligned just after a tick, wait, inspect.
    for (int i = 0; i < 7; i++) begin
      align_idle();
      base = tmo_cnt;
      pulse(1'b1, 1'b0, vecs[i].tmo);
      if (vecs[i].ticks > 0) wait_ticks(vecs[i].ticks);
      cycles(2);
      check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_expired", i), bus.expired, vecs[i].exp_expired);
      check($sformatf("vec%0d_timeouts", i), tmo_cnt - base, vecs[i].exp_tmo);
    end

    // timeout_ms=3: exact pulse timing, timeout_ms changes ignored, stop clears.
    align_idle();
    base = tmo_cnt;
    pulse(1'b1, 1'b0, 8'd3);
    check("t3_busy_next_cycle", bus.busy, 1);
    bus.timeout_ms = 8'd200;
    wait_ticks(2);
    check("t3_no_early_timeout", tmo_cnt - base, 0);
    wait_ticks(1);
    cycles(1);
    check("t3_timeout_after_tick", last_tmo_cyc - last_tick_cyc, 1);
    check("t3_expired", bus.expired, 1);
    check("t3_busy_low", bus.busy, 0);
    cycles(3);
    check("t3_single_pulse", tmo_cnt - base, 1);
    pulse(1'b0, 1'b1, 8'd0);
    check("t3_stop_clears", bus.expired, 0);

    // timeout_ms=0: pulse and expired in the cycle right after start.
    align_idle();
    base = tmo_cnt;
    pulse(1'b1, 1'b0, 8'd0);
    check("t0_timeout_cycle", last_tmo_cyc, pulse_cyc);
    check("t0_expired", bus.expired, 1);
    check("t0_count", tmo_cnt - base, 1);

    // Restart: 5 ms then after 4 ticks restart with 2 ms.
    align_idle();
    base = tmo_cnt;
    pulse(1'b1, 1'b0, 8'd5);
    wait_ticks(4);
    pulse(1'b1, 1'b0, 8'd2);
    wait_ticks(1);
    cycles(2);
    check("rs_no_timeout_tick5", tmo_cnt - base, 0);
    check("rs_busy_tick5", bus.busy, 1);
    wait_ticks(1);
    cycles(2);
    check("rs_timeout", tmo_cnt - base, 1);
    check("rs_expired", bus.expired, 1);

    // start+stop together while RUNNING -> IDLE, never times out.
    align_idle();
    pulse(1'b1, 1'b0, 8'd3);
    wait_ticks(1);
    base = tmo_cnt;
    pulse(1'b1, 1'b1, 8'd3);
    check("ss_busy", bus.busy, 0);
    check("ss_expired", bus.expired, 0);
    wait_ticks(4);
    cycles(2);
    check("ss_no_timeout", tmo_cnt - base, 0);
    check("ss_still_idle", bus.busy, 0);

`ifdef TIMER_ELAPSED_EN
    // elapsed_ms: 0,1,2,3,4 then held at 4; start zeroes it.
    align_idle();
    pulse(1'b1, 1'b0, 8'd4);
    check("el_zero", bus.elapsed_ms, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_ticks(1);
      cycles(2);
      check($sformatf("el_step%0d", k), bus.elapsed_ms, (k < 4) ? k : 4);
    end
    check("el_expired", bus.expired, 1);
    pulse(1'b0, 1'b1, 8'd0);
    check("el_hold_after_stop", bus.elapsed_ms, 4);
    pulse(1'b1, 1'b0, 8'd4);
    check("el_start_zero", bus.elapsed_ms, 0);
`endif

    cycles(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
